// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter of NUM_REQ write-back requests onto NUM_PORTS register file write ports, 1-cycle latency.
// Backpressure: combinational io_req_ready (stall, address conflict, port exhaustion); REGFILE_ARB_STATS_EN adds counters.
module regfile_write_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int NUM_PORTS = 2,
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 64
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic                           io_stall,
  input  logic [NUM_REQ-1:0]             io_req_valid,
  output logic [NUM_REQ-1:0]             io_req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0]      io_req_address,
  input  logic [NUM_REQ*DATA_W-1:0]      io_req_value,
  input  logic [NUM_REQ*DATA_W/8-1:0]    io_req_byteMask,
  output logic [NUM_PORTS-1:0]           io_write_write,
  output logic [NUM_PORTS*ADDR_W-1:0]    io_write_address,
  output logic [NUM_PORTS*DATA_W-1:0]    io_write_value,
  output logic [NUM_PORTS*DATA_W/8-1:0]  io_write_byteMask,
  output logic                           io_busy
`ifdef REGFILE_ARB_STATS_EN
  ,
  output logic [31:0]                    io_stat_grants,
  output logic [31:0]                    io_stat_conflicts,
  output logic [31:0]                    io_stat_stalls
`endif
);

  localparam int MASK_W = DATA_W / 8;
  localparam int PTR_W  = $clog2(NUM_REQ);

  logic [PTR_W-1:0]            r_rr_ptr;
  logic [PTR_W-1:0]            w_rr_next;
  logic [NUM_PORTS-1:0]        r_write;
  logic [NUM_PORTS*ADDR_W-1:0] r_addr;
  logic [NUM_PORTS*DATA_W-1:0] r_value;
  logic [NUM_PORTS*MASK_W-1:0] r_mask;

  logic [NUM_REQ-1:0]          w_ready;
  logic [NUM_PORTS-1:0]        w_pwr;
  logic [NUM_PORTS*ADDR_W-1:0] w_paddr;
  logic [NUM_PORTS*DATA_W-1:0] w_pval;
  logic [NUM_PORTS*MASK_W-1:0] w_pmask;
  logic                        w_any_defer;
  logic                        w_any_grant;
  logic [PTR_W-1:0]            w_first_defer;
  logic [PTR_W-1:0]            w_last_grant;
  int                          w_nused;
  int                          w_idx;
  logic                        w_sel_vld;
  logic [ADDR_W-1:0]           w_sel_addr;
  logic [DATA_W-1:0]           w_sel_val;
  logic [MASK_W-1:0]           w_sel_mask;
  logic                        w_conflict;
  logic                        w_take;

  // Ports fill in scan order, so the lowest free port is always index w_nused.
  always_comb begin
    w_ready       = '0;
    w_pwr         = '0;
    w_paddr       = '0;
    w_pval        = '0;
    w_pmask       = '0;
    w_any_defer   = 1'b0;
    w_any_grant   = 1'b0;
    w_first_defer = '0;
    w_last_grant  = '0;
    w_nused       = 0;
    w_idx         = 0;
    w_sel_vld     = 1'b0;
    w_sel_addr    = '0;
    w_sel_val     = '0;
    w_sel_mask    = '0;
    w_conflict    = 1'b0;
    w_take        = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = int'(r_rr_ptr) + k;
      if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
      w_sel_vld  = 1'b0;
      w_sel_addr = '0;
      w_sel_val  = '0;
      w_sel_mask = '0;
      for (int r = 0; r < NUM_REQ; r++) begin
        if (r == w_idx) begin
          w_sel_vld  = io_req_valid[r];
          w_sel_addr = io_req_address[r*ADDR_W +: ADDR_W];
          w_sel_val  = io_req_value[r*DATA_W +: DATA_W];
          w_sel_mask = io_req_byteMask[r*MASK_W +: MASK_W];
        end
      end
      w_conflict = 1'b0;
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (w_pwr[p] && (w_paddr[p*ADDR_W +: ADDR_W] == w_sel_addr)) w_conflict = 1'b1;
      end
      w_take = 1'b0;
      if (w_sel_vld && !io_stall) begin
        if (w_sel_mask == '0) begin
          w_take = 1'b1;
        end else if (w_conflict) begin
          if (!w_any_defer) w_first_defer = PTR_W'(w_idx);
          w_any_defer = 1'b1;
        end else if (w_nused < NUM_PORTS) begin
          for (int p = 0; p < NUM_PORTS; p++) begin
            if (p == w_nused) begin
              w_pwr[p]                     = 1'b1;
              w_paddr[p*ADDR_W +: ADDR_W]  = w_sel_addr;
              w_pval[p*DATA_W +: DATA_W]   = w_sel_val;
              w_pmask[p*MASK_W +: MASK_W]  = w_sel_mask;
            end
          end
          w_nused      = w_nused + 1;
          w_take       = 1'b1;
          w_any_grant  = 1'b1;
          w_last_grant = PTR_W'(w_idx);
        end
      end
      for (int r = 0; r < NUM_REQ; r++) begin
        if ((r == w_idx) && w_take) w_ready[r] = 1'b1;
      end
    end
  end

  // Restarting at the first deferred requester keeps conflicting writers from starving.
  always_comb begin
    w_rr_next = r_rr_ptr;
    if (w_any_defer) w_rr_next = w_first_defer;
    else if (w_any_grant) w_rr_next = (int'(w_last_grant) == NUM_REQ - 1) ? '0 : w_last_grant + 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rr_ptr <= '0;
      r_write  <= '0;
      r_addr   <= '0;
      r_value  <= '0;
      r_mask   <= '0;
    end else begin
      r_rr_ptr <= w_rr_next;
      r_write  <= w_pwr;
      r_addr   <= w_paddr;
      r_value  <= w_pval;
      r_mask   <= w_pmask;
    end
  end

  assign io_req_ready      = w_ready;
  assign io_write_write    = r_write;
  assign io_write_address  = r_addr;
  assign io_write_value    = r_value;
  assign io_write_byteMask = r_mask;
  assign io_busy           = |r_write;

`ifdef REGFILE_ARB_STATS_EN
  logic [31:0] r_stat_grants;
  logic [31:0] r_stat_conflicts;
  logic [31:0] r_stat_stalls;
  logic [32:0] w_grant_sum;

  assign w_grant_sum = {1'b0, r_stat_grants} + 33'(w_nused);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_stat_grants    <= '0;
      r_stat_conflicts <= '0;
      r_stat_stalls    <= '0;
    end else begin
      r_stat_grants <= w_grant_sum[32] ? 32'hFFFF_FFFF : w_grant_sum[31:0];
      if (w_any_defer && (r_stat_conflicts != 32'hFFFF_FFFF))
        r_stat_conflicts <= r_stat_conflicts + 32'd1;
      if (io_stall && (|io_req_valid) && (r_stat_stalls != 32'hFFFF_FFFF))
        r_stat_stalls <= r_stat_stalls + 32'd1;
    end
  end

  assign io_stat_grants    = r_stat_grants;
  assign io_stat_conflicts = r_stat_conflicts;
  assign io_stat_stalls    = r_stat_stalls;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench for regfile_write_arbiter: stimulus pushes expected port writes, a negedge monitor pops and compares.
module tb_regfile_write_arbiter;
  localparam int NR = 4;
  localparam int NP = 2;
  localparam int AW = 5;
  localparam int DW = 64;
  localparam int MW = DW / 8;

  logic              clock;
  logic              reset_n;
  logic              io_stall;
  logic [NR-1:0]     io_req_valid;
  logic [NR-1:0]     io_req_ready;
  logic [NR*AW-1:0]  io_req_address;
  logic [NR*DW-1:0]  io_req_value;
  logic [NR*MW-1:0]  io_req_byteMask;
  logic [NP-1:0]     io_write_write;
  logic [NP*AW-1:0]  io_write_address;
  logic [NP*DW-1:0]  io_write_value;
  logic [NP*MW-1:0]  io_write_byteMask;
  logic              io_busy;

  regfile_write_arbiter #(.NUM_REQ(NR), .NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clock(clock), .reset_n(reset_n), .io_stall(io_stall),
    .io_req_valid(io_req_valid), .io_req_ready(io_req_ready),
    .io_req_address(io_req_address), .io_req_value(io_req_value),
    .io_req_byteMask(io_req_byteMask), .io_write_write(io_write_write),
    .io_write_address(io_write_address), .io_write_value(io_write_value),
    .io_write_byteMask(io_write_byteMask), .io_busy(io_busy)
  );

  typedef struct {
    int           port;
    logic [AW-1:0] addr;
    logic [DW-1:0] val;
    logic [MW-1:0] mask;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push(input int p, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [MW-1:0] m);
    exp_t e;
    e.port = p; e.addr = a; e.val = d; e.mask = m;
    sb_q.push_back(e);
  endtask

  task automatic set_req(input int i, input logic v, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [MW-1:0] m);
    io_req_valid[i]                 = v;
    io_req_address[i*AW +: AW]      = a;
    io_req_value[i*DW +: DW]        = d;
    io_req_byteMask[i*MW +: MW]     = m;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_reqs();
    io_req_valid    = '0;
    io_req_address  = '0;
    io_req_value    = '0;
    io_req_byteMask = '0;
  endtask

  task automatic do_reset();
    clear_reqs();
    io_stall = 1'b0;
    step();
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
  endtask

  // Scoreboard monitor: every asserted port must match the oldest expected write.
  always @(negedge clock) begin
    if (reset_n) begin
      for (int p = 0; p < NP; p++) begin
        if (io_write_write[p]) begin
          if (sb_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_write: port %0d addr %0h with empty scoreboard at %0t",
                     p, io_write_address[p*AW +: AW], $time);
          end else begin
            exp_t e;
            e = sb_q.pop_front();
            check("wr_port", 64'(p), 64'(e.port));
            check("wr_addr", 64'(io_write_address[p*AW +: AW]), 64'(e.addr));
            check("wr_value", io_write_value[p*DW +: DW], e.val);
            check("wr_mask", 64'(io_write_byteMask[p*MW +: MW]), 64'(e.mask));
          end
        end else begin
          check("idle_addr_zero", 64'(io_write_address[p*AW +: AW]), 64'd0);
          check("idle_value_zero", io_write_value[p*DW +: DW], 64'd0);
          check("idle_mask_zero", 64'(io_write_byteMask[p*MW +: MW]), 64'd0);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset_n  = 1'b0;
    io_stall = 1'b0;
    clear_reqs();
    #12;
    reset_n = 1'b1;

    // Idle after reset
    for (int c = 0; c < 10; c++) begin
      step();
      #2;
      check("rst_write", 64'(io_write_write), 64'd0);
      check("rst_busy", 64'(io_busy), 64'd0);
      check("rst_ready", 64'(io_req_ready), 64'd0);
    end

    // Single write from req0
    step();
    set_req(0, 1'b1, 5'd3, 64'hDEAD_BEEF_0123_4567, 8'hFF);
    #2;
    check("single_ready", 64'(io_req_ready), 64'h1);
    push(0, 5'd3, 64'hDEAD_BEEF_0123_4567, 8'hFF);
    step();
    set_req(0, 1'b0, 5'd0, 64'd0, 8'h00);
    #2;
    check("single_write", 64'(io_write_write), 64'h1);
    check("single_busy", 64'(io_busy), 64'd1);
    step();
    #2;
    check("single_after", 64'(io_write_write), 64'd0);

    // Four requesters, two ports: two cycles of grants
    do_reset();
    step();
    for (int i = 0; i < NR; i++)
      set_req(i, 1'b1, AW'(i + 1), 64'h1111_0000_0000_0000 * (i + 1), 8'hFF);
    #2;
    check("all4_ready_c1", 64'(io_req_ready), 64'h3);
    push(0, 5'd1, 64'h1111_0000_0000_0000, 8'hFF);
    push(1, 5'd2, 64'h2222_0000_0000_0000, 8'hFF);
    step();
    set_req(0, 1'b0, 5'd0, 64'd0, 8'h00);
    set_req(1, 1'b0, 5'd0, 64'd0, 8'h00);
    #2;
    check("all4_ready_c2", 64'(io_req_ready), 64'hC);
    check("all4_write_c2", 64'(io_write_write), 64'h3);
    push(0, 5'd3, 64'h3333_0000_0000_0000, 8'hFF);
    push(1, 5'd4, 64'h4444_0000_0000_0000, 8'hFF);
    step();
    clear_reqs();
    #2;
    check("all4_write_c3", 64'(io_write_write), 64'h3);
    step();

    // Same-address conflict: deferral steers rr_ptr to the deferred requester
    do_reset();
    step();
    set_req(0, 1'b1, 5'd7, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F);
    set_req(2, 1'b1, 5'd7, 64'hBBBB_BBBB_BBBB_BBBB, 8'hF0);
    #2;
    check("conf_ready_c1", 64'(io_req_ready), 64'h1);
    push(0, 5'd7, 64'hAAAA_AAAA_AAAA_AAAA, 8'h0F);
    step();
    set_req(0, 1'b0, 5'd0, 64'd0, 8'h00);
    set_req(1, 1'b1, 5'd7, 64'hCCCC_CCCC_CCCC_CCCC, 8'hFF);
    #2;
    check("conf_ready_c2", 64'(io_req_ready), 64'h4);
    push(0, 5'd7, 64'hBBBB_BBBB_BBBB_BBBB, 8'hF0);
    step();
    set_req(2, 1'b0, 5'd0, 64'd0, 8'h00);
    #2;
    check("conf_ready_c3", 64'(io_req_ready), 64'h2);
    check("conf_write_c3", 64'(io_write_write), 64'h1);
    push(0, 5'd7, 64'hCCCC_CCCC_CCCC_CCCC, 8'hFF);
    step();
    clear_reqs();
    #2;
    check("conf_write_c4", 64'(io_write_write), 64'h1);
    step();

    // Zero-mask request is accepted but never written
    do_reset();
    step();
    set_req(0, 1'b1, 5'd10, 64'h0A0A_0A0A_0A0A_0A0A, 8'h3C);
    set_req(1, 1'b1, 5'd11, 64'h0B0B_0B0B_0B0B_0B0B, 8'h00);
    set_req(2, 1'b1, 5'd12, 64'h0C0C_0C0C_0C0C_0C0C, 8'h81);
    #2;
    check("zmask_ready", 64'(io_req_ready), 64'h7);
    push(0, 5'd10, 64'h0A0A_0A0A_0A0A_0A0A, 8'h3C);
    push(1, 5'd12, 64'h0C0C_0C0C_0C0C_0C0C, 8'h81);
    step();
    clear_reqs();
    #2;
    check("zmask_write", 64'(io_write_write), 64'h3);
    step();

    // Stall holds everything, then async reset mid-operation
    do_reset();
    step();
    for (int i = 0; i < NR; i++)
      set_req(i, 1'b1, AW'(20 + i), 64'h5000_0000_0000_0000 + i, 8'hFF);
    io_stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #2;
      check("stall_ready", 64'(io_req_ready), 64'd0);
      check("stall_write", 64'(io_write_write), 64'd0);
      step();
    end
    io_stall = 1'b0;
    #2;
    check("unstall_ready", 64'(io_req_ready), 64'h3);
    step();
    check("pre_reset_write", 64'(io_write_write), 64'h3);
    #1;
    reset_n = 1'b0;
    #1;
    check("reset_write_clear", 64'(io_write_write), 64'd0);
    check("reset_busy_clear", 64'(io_busy), 64'd0);
    check("reset_addr_clear", 64'(io_write_address), 64'd0);
    step();
    reset_n = 1'b1;
    #2;
    check("post_reset_ready", 64'(io_req_ready), 64'h3);
    push(0, 5'd20, 64'h5000_0000_0000_0000, 8'hFF);
    push(1, 5'd21, 64'h5000_0000_0000_0001, 8'hFF);
    step();
    set_req(0, 1'b0, 5'd0, 64'd0, 8'h00);
    set_req(1, 1'b0, 5'd0, 64'd0, 8'h00);
    #2;
    check("post_reset_ready2", 64'(io_req_ready), 64'hC);
    push(0, 5'd22, 64'h5000_0000_0000_0002, 8'hFF);
    push(1, 5'd23, 64'h5000_0000_0000_0003, 8'hFF);
    step();
    clear_reqs();
    #2;
    check("post_reset_write", 64'(io_write_write), 64'h3);
    step();
    step();
    #2;
    check("final_idle", 64'(io_busy), 64'd0);
    check("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
- Shares the NUM_PORTS byte-masked write ports of the 32x64 register file among NUM_REQ write-back requesters, such as ALU lanes and load return.
- Grants requesters round-robin each cycle and keeps two writes to the same register out of the same cycle.
- Drives the register file write ports from a registered output stage.
- Sits between the execution lanes and the register file write interface.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- NUM_PORTS, 2, number of register file write ports driven (1..NUM_REQ)
- ADDR_W, 5, register address width
- DATA_W, 64, write data width; byte mask width is DATA_W/8

Ports:
- clock  in  1  sole clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- io_stall  in  1  when high: no grants this cycle
- io_req_valid  in  NUM_REQ  per-requester write request
- io_req_ready  out  NUM_REQ  per-requester grant (combinational)
- io_req_address  in  NUM_REQ*ADDR_W  packed, requester i at [i*ADDR_W +: ADDR_W]
- io_req_value  in  NUM_REQ*DATA_W  packed write data
- io_req_byteMask  in  NUM_REQ*DATA_W/8  packed byte masks
- io_write_write  out  NUM_PORTS  write enable per port (registered)
- io_write_address  out  NUM_PORTS*ADDR_W  packed port address
- io_write_value  out  NUM_PORTS*DATA_W  packed port data
- io_write_byteMask  out  NUM_PORTS*DATA_W/8  packed port mask
- io_busy  out  1  OR of io_write_write

Behaviour:
- Reset (reset_n low, asynchronous): all io_write_* zero, rr_ptr = 0, io_busy = 0. Any in-flight output is discarded.
- Handshake: a transfer happens when io_req_valid[i] && io_req_ready[i] at a rising edge. io_req_ready depends combinationally on io_req_valid. Requesters must hold valid, address, value and mask stable until granted.
- Scan order each cycle: rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
- For each valid requester in scan order:
  - mask == 0: ready=1, request dropped, no port used.
  - else if its address equals an address already granted this cycle: deferred, ready=0.
  - else if a free port remains: granted to the lowest free port index.
  - else: not granted (port exhaustion).
- io_stall=1: all ready=0 and rr_ptr holds. The output stage still updates, so io_write_write=0 on the next cycle.
- Output stage: granted request appears on its port one cycle after the handshake edge, with write=1 for exactly one cycle. Unused ports have write=0; address, value and mask on those ports are don't-care but held at zero.
- Latency: 1 cycle, request to write enable. Throughput: up to NUM_PORTS writes per cycle.
- rr_ptr update, in priority order:
  - if any requester was deferred: set to the first deferred index in scan order, which guarantees no starvation on conflicts;
  - else if any port grant: set to last granted index + 1, mod NUM_REQ;
  - else unchanged.
- Zero-mask drops do not count as grants for rr_ptr.
- Ordering: two writes to the same address from different requesters are never issued in the same cycle. The issue order between them is the grant order.
- Bound: each continuously valid requester is granted within NUM_REQ cycles while io_stall=0.

Optional Feature:
- REGFILE_ARB_STATS_EN defined: adds the following outputs, all reset to 0:
  - io_stat_grants, 32 bits: total port grants;
  - io_stat_conflicts, 32 bits: cycles with at least one address deferral;
  - io_stat_stalls, 32 bits: cycles with io_stall=1 and any valid request.
  - All three counters saturate at 32'hFFFF_FFFF.
- Undefined: these ports and their counters do not exist, and behaviour is otherwise identical.

Test Plan:
- Reset release, no requests -> io_write_write=0 and io_busy=0 for 10 cycles, every io_req_ready=0 (no valid inputs).
- Req0 addr 3, value 64'hDEAD_BEEF_0123_4567, mask 8'hFF, single cycle -> ready[0]=1; next cycle port0 write=1, addr 3, same value and mask; following cycle write=0.
- All 4 requesters valid, distinct addresses 1/2/3/4, rr_ptr=0, held -> cycle 1 grants req0,req1 (ports 0,1), rr_ptr=2; cycle 2 grants req2,req3; all four written within 2 cycles.
- Req0 and req2 both addr 7, masks 8'h0F and 8'hF0 -> req0 granted, req2 deferred, rr_ptr=2; next cycle req2 granted. Register 7 receives both writes on consecutive cycles.
- Req1 mask 8'h00 together with req0 and req2 valid -> req1 ready=1 and never appears on a port; req0 and req2 occupy ports 0 and 1.
- Requests held, io_stall=1 for 3 cycles, then reset_n pulsed low mid-operation -> no grants while stalled; on reset assertion outputs clear immediately and rr_ptr=0.
